ysyx_22041211_lsu: RTL and testbench

Load/store unit. It is the initiator of the core's data-memory interface and sits between the execute stage and ysyx_22041211 data memory or the bus bridge. It accepts one load or store per handshake and generates a word-aligned memory request with a byte mask and lane-shifted write data. It extracts and sign- or zero-extends load data and reports misalignment and timeout errors.

---
 rtl/ysyx_22041211_lsu_pkg.sv | 19 +
 rtl/ysyx_22041211_lsu_align.sv | 55 +++++
 rtl/ysyx_22041211_lsu.sv | 154 +++++++++++++++
 tb/tb_ysyx_22041211_lsu.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041211_lsu_pkg.sv
// Shared encodings for the load/store unit: FSM states, access sizes and error codes.
package ysyx_22041211_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Combinational byte-lane logic: alignment check, store mask/data shift, load extraction.
module ysyx_22041211_lsu_align
    import ysyx_22041211_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        aligned,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [31:0] rdata_shifted;

    assign wdata_lane    = wdata << {offset, 3'b000};
    assign rdata_shifted = rdata >> {offset, 3'b000};

    always_comb begin
        aligned = 1'b0;
        wmask   = 4'b0000;
        case (funct3[1:0])
            SZ_B: begin
                aligned = 1'b1;
                wmask   = 4'b0001 << offset;
            end
            SZ_H: begin
                aligned = ~offset[0];
                wmask   = 4'b0011 << offset;
            end
            SZ_W: begin
                aligned = (offset == 2'b00);
                wmask   = 4'b1111;
            end
            default: begin
                aligned = 1'b0;
                wmask   = 4'b0000;
            end
        endcase
    end

    // funct3[2] selects zero extension for LBU/LHU.
    always_comb begin
        load_data = rdata_shifted;
        case (funct3[1:0])
            SZ_B: load_data = funct3[2] ? {24'b0, rdata_shifted[7:0]}
                                        : {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            SZ_H: load_data = funct3[2] ? {16'b0, rdata_shifted[15:0]}
                                        : {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
            default: load_data = rdata_shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit: one access per handshake, word-aligned memory request with byte
// mask, registered extended load data, misalignment and timeout reporting.
module ysyx_22041211_lsu
    import ysyx_22041211_lsu_pkg::*;
#(
    parameter int DATA_LEN       = 32,
    parameter int ADDR_LEN       = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic                lsu_wen_i,
    input  logic [2:0]          lsu_funct3_i,
    input  logic [ADDR_LEN-1:0] lsu_addr_i,
    input  logic [DATA_LEN-1:0] lsu_wdata_i,
    output logic                lsu_done_o,
    output logic [DATA_LEN-1:0] lsu_rdata_o,
    output logic [1:0]          lsu_err_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    output logic                mem_wen_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [3:0]          mem_wmask_o,
    input  logic                mem_resp_valid_i,
    input  logic [DATA_LEN-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e          state_q, state_d;
    logic                wen_q;
    logic [2:0]          funct3_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_LEN-1:0] rdata_q;
    logic [1:0]          err_q;

    logic [2:0]          chk_funct3;
    logic [1:0]          chk_offset;
    logic                aligned;
    logic [3:0]          wmask;
    logic [DATA_LEN-1:0] wdata_lane;
    logic [DATA_LEN-1:0] load_data;
    logic                timeout_hit;
    logic                result_en;
    logic [1:0]          result_err;
    logic [DATA_LEN-1:0] result_rdata;
    logic                in_req;

    // In IDLE the alignment check must see the incoming access, afterwards the latched one.
    assign chk_funct3  = (state_q == ST_IDLE) ? lsu_funct3_i : funct3_q;
    assign chk_offset  = (state_q == ST_IDLE) ? lsu_addr_i[1:0] : addr_q[1:0];
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    ysyx_22041211_lsu_align u_align (
        .funct3     (chk_funct3),
        .offset     (chk_offset),
        .wdata      (wdata_q),
        .rdata      (mem_rdata_i),
        .aligned    (aligned),
        .wmask      (wmask),
        .wdata_lane (wdata_lane),
        .load_data  (load_data)
    );

    always_comb begin
        state_d      = state_q;
        result_en    = 1'b0;
        result_err   = ERR_NONE;
        result_rdata = '0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_valid_i) begin
                    if (aligned) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_DONE;
                        result_en  = 1'b1;
                        result_err = ERR_ALIGN;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready_i) begin
                    state_d = ST_WAIT;
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    result_en  = 1'b1;
                    result_err = ERR_TIMEOUT;
                end
            end
            ST_WAIT: begin
                if (mem_resp_valid_i) begin
                    state_d      = ST_DONE;
                    result_en    = 1'b1;
                    result_err   = ERR_NONE;
                    result_rdata = wen_q ? '0 : load_data;
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    result_en  = 1'b1;
                    result_err = ERR_TIMEOUT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wen_q    <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && lsu_valid_i) begin
                wen_q    <= lsu_wen_i;
                funct3_q <= lsu_funct3_i;
                addr_q   <= lsu_addr_i;
                wdata_q  <= lsu_wdata_i;
            end
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
            end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (result_en) begin
                rdata_q <= result_rdata;
                err_q   <= result_err;
            end
        end
    end

    assign in_req          = (state_q == ST_REQ);
    assign lsu_ready_o     = (state_q == ST_IDLE);
    assign lsu_done_o      = (state_q == ST_DONE);
    assign lsu_rdata_o     = lsu_done_o ? rdata_q : '0;
    assign lsu_err_o       = lsu_done_o ? err_q : ERR_NONE;
    assign mem_req_valid_o = in_req;
    assign mem_addr_o      = in_req ? {addr_q[ADDR_LEN-1:2], 2'b00} : '0;
    assign mem_wen_o       = in_req & wen_q;
    assign mem_wdata_o     = in_req ? wdata_lane : '0;
    assign mem_wmask_o     = in_req ? wmask : 4'b0000;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Directed bench for the LSU: stimulus pushes expected completions into a queue that a
// monitor pops on every done pulse; request-side signals are checked inline.
module tb_ysyx_22041211_lsu;

    typedef struct packed {
        logic [31:0] rdata;
        logic [1:0]  err;
        logic [31:0] cycle;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic        lsu_wen_i = 1'b0;
    logic [2:0]  lsu_funct3_i = 3'b0;
    logic [31:0] lsu_addr_i = 32'b0;
    logic [31:0] lsu_wdata_i = 32'b0;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic [1:0]  lsu_err_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_wen_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'b0;

    int   cyc = 0;
    int   numChecks = 0;
    int   numFails = 0;
    exp_t expQ[$];

    ysyx_22041211_lsu #(
        .DATA_LEN       (32),
        .ADDR_LEN       (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .lsu_valid_i      (lsu_valid_i),
        .lsu_ready_o      (lsu_ready_o),
        .lsu_wen_i        (lsu_wen_i),
        .lsu_funct3_i     (lsu_funct3_i),
        .lsu_addr_i       (lsu_addr_i),
        .lsu_wdata_i      (lsu_wdata_i),
        .lsu_done_o       (lsu_done_o),
        .lsu_rdata_o      (lsu_rdata_o),
        .lsu_err_o        (lsu_err_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_wen_o        (mem_wen_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_wmask_o      (mem_wmask_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && lsu_done_o) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("done_rdata", lsu_rdata_o, e.rdata);
                checkOutput("done_err", {30'b0, lsu_err_o}, {30'b0, e.err});
                checkOutput("done_cycle", cyc, e.cycle);
            end
        end
    end

    task automatic checkReq(input string name, input logic wen, input logic [31:0] addr,
                            input logic [3:0] mask, input logic [31:0] mwdata);
        checkOutput({name, " req_valid"}, {31'b0, mem_req_valid_o}, 32'd1);
        checkOutput({name, " mem_addr"}, mem_addr_o, {addr[31:2], 2'b00});
        checkOutput({name, " mem_wen"}, {31'b0, mem_wen_o}, {31'b0, wen});
        checkOutput({name, " mem_wmask"}, {28'b0, mem_wmask_o}, {28'b0, mask});
        checkOutput({name, " mem_wdata"}, mem_wdata_o, mwdata);
    endtask

    task automatic checkIdleReq(input string name);
        checkOutput({name, " req_off"}, {31'b0, mem_req_valid_o}, 32'd0);
        checkOutput({name, " addr_off"}, mem_addr_o, 32'd0);
        checkOutput({name, " mask_off"}, {28'b0, mem_wmask_o}, 32'd0);
    endtask

    // readyWait/respWait < 0 means the memory never answers in that phase.
    // expLat counts clock edges from the accept edge to the edge entering DONE.
    task automatic applyStimulus(input string name, input logic wen, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int readyWait, input int respWait,
                                 input logic [31:0] memRdata, input logic [3:0] expMask,
                                 input logic [31:0] expMemWdata, input logic [31:0] expRdata,
                                 input logic [1:0] expErr, input int expLat);
        int acc;
        exp_t e;
        checkOutput({name, " ready_before"}, {31'b0, lsu_ready_o}, 32'd1);
        lsu_valid_i  = 1'b1;
        lsu_wen_i    = wen;
        lsu_funct3_i = f3;
        lsu_addr_i   = addr;
        lsu_wdata_i  = wdata;
        step();
        lsu_valid_i = 1'b0;
        lsu_wdata_i = 32'hFFFF_FFFF;
        lsu_addr_i  = 32'hFFFF_FFFF;
        acc = cyc;
        e.rdata = expRdata;
        e.err   = expErr;
        e.cycle = acc + expLat;
        expQ.push_back(e);
        if (expLat == 0) begin
            checkIdleReq(name);
        end else if (readyWait < 0) begin
            while (cyc < acc + expLat) begin
                checkReq(name, wen, addr, expMask, expMemWdata);
                step();
            end
            checkIdleReq(name);
        end else begin
            for (int i = 0; i < readyWait; i++) begin
                checkReq(name, wen, addr, expMask, expMemWdata);
                step();
            end
            checkReq(name, wen, addr, expMask, expMemWdata);
            mem_req_ready_i = 1'b1;
            step();
            mem_req_ready_i = 1'b0;
            checkIdleReq(name);
            if (respWait >= 0) begin
                repeat (respWait) step();
                mem_resp_valid_i = 1'b1;
                mem_rdata_i      = memRdata;
                step();
                mem_resp_valid_i = 1'b0;
                mem_rdata_i      = 32'h0;
            end
        end
        while (cyc < acc + expLat + 1) step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting LSU bench");
        repeat (3) step();
        rst = 1'b0;
        checkOutput("reset ready", {31'b0, lsu_ready_o}, 32'd1);
        checkOutput("reset done", {31'b0, lsu_done_o}, 32'd0);
        checkOutput("reset rdata", lsu_rdata_o, 32'd0);
        checkOutput("reset err", {30'b0, lsu_err_o}, 32'd0);
        checkOutput("reset wen", {31'b0, mem_wen_o}, 32'd0);
        checkOutput("reset wdata", mem_wdata_o, 32'd0);
        checkIdleReq("reset");
        step();

        //            name      wen  f3      addr          wdata         rw  rsp  memRdata      mask     memWdata      rdata         err    lat
        applyStimulus("lw",     0, 3'b010, 32'h8000_0004, 32'h0,        0,  0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        32'hDEAD_BEEF, 2'b00, 2);
        applyStimulus("lb",     0, 3'b000, 32'h8000_0003, 32'h0,        0,  0, 32'h80FF_FF7F, 4'b1000, 32'h0,        32'hFFFF_FF80, 2'b00, 2);
        applyStimulus("lbu",    0, 3'b100, 32'h8000_0003, 32'h0,        0,  0, 32'h80FF_FF7F, 4'b1000, 32'h0,        32'h0000_0080, 2'b00, 2);
        applyStimulus("lb_pos", 0, 3'b000, 32'h8000_0001, 32'h0,        0,  1, 32'h0000_7F00, 4'b0010, 32'h0,        32'h0000_007F, 2'b00, 3);
        applyStimulus("lh",     0, 3'b001, 32'h8000_0002, 32'h0,        0,  0, 32'h8001_1234, 4'b1100, 32'h0,        32'hFFFF_8001, 2'b00, 2);
        applyStimulus("lhu",    0, 3'b101, 32'h8000_0002, 32'h0,        0,  0, 32'h8001_1234, 4'b1100, 32'h0,        32'h0000_8001, 2'b00, 2);
        applyStimulus("lh_lo",  0, 3'b001, 32'h8000_0000, 32'h0,        0,  0, 32'hFFFF_7FFF, 4'b0011, 32'h0,        32'h0000_7FFF, 2'b00, 2);
        applyStimulus("sh",     1, 3'b001, 32'h8000_0002, 32'h0000_ABCD, 0, 0, 32'h1234_5678, 4'b1100, 32'hABCD_0000, 32'h0,        2'b00, 2);
        applyStimulus("sb_stl", 1, 3'b000, 32'h8000_0001, 32'h0000_00A5, 3, 0, 32'h1234_5678, 4'b0010, 32'h0000_A500, 32'h0,        2'b00, 5);
        applyStimulus("sw",     1, 3'b010, 32'h8000_0008, 32'h1122_3344, 0, 2, 32'h0,        4'b1111, 32'h1122_3344, 32'h0,        2'b00, 4);
        applyStimulus("lw_mis", 0, 3'b010, 32'h8000_0002, 32'h0,        0,  0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b01, 0);
        applyStimulus("sh_mis", 1, 3'b001, 32'h8000_0001, 32'h0000_1234, 0, 0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b01, 0);
        applyStimulus("sz11",   0, 3'b011, 32'h8000_0000, 32'h0,        0,  0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b01, 0);
        applyStimulus("sz11u",  0, 3'b111, 32'h8000_0004, 32'h0,        0,  0, 32'h0,        4'b0000, 32'h0,        32'h0,        2'b01, 0);
        applyStimulus("resp_c8",0, 3'b010, 32'h8000_0010, 32'h0,        0,  6, 32'hCAFE_F00D, 4'b1111, 32'h0,        32'hCAFE_F00D, 2'b00, 8);
        applyStimulus("rdy3r3", 0, 3'b010, 32'h8000_0014, 32'h0,        3,  3, 32'h0BAD_CAFE, 4'b1111, 32'h0,        32'h0BAD_CAFE, 2'b00, 8);
        applyStimulus("to_req", 1, 3'b010, 32'h8000_0018, 32'h5555_AAAA, -1, 0, 32'h0,       4'b1111, 32'h5555_AAAA, 32'h0,        2'b10, 8);
        applyStimulus("to_wait",0, 3'b010, 32'h8000_0020, 32'h0,        0, -1, 32'h0,        4'b1111, 32'h0,        32'h0,        2'b10, 8);

        // A response after the timeout must not produce any completion.
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'h1111_2222;
        step();
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = 32'h0;
        checkOutput("late_resp ready", {31'b0, lsu_ready_o}, 32'd1);
        checkOutput("late_resp done", {31'b0, lsu_done_o}, 32'd0);
        step();

        // Reset while in WAIT aborts silently.
        lsu_valid_i  = 1'b1;
        lsu_wen_i    = 1'b0;
        lsu_funct3_i = 3'b010;
        lsu_addr_i   = 32'h8000_0040;
        step();
        lsu_valid_i     = 1'b0;
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkOutput("midrst ready", {31'b0, lsu_ready_o}, 32'd1);
        checkOutput("midrst done", {31'b0, lsu_done_o}, 32'd0);
        checkOutput("midrst rdata", lsu_rdata_o, 32'd0);
        checkOutput("midrst err", {30'b0, lsu_err_o}, 32'd0);
        checkIdleReq("midrst");
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = 32'h7777_8888;
        step();
        mem_resp_valid_i = 1'b0;
        mem_rdata_i      = 32'h0;
        checkOutput("post_rst_resp done", {31'b0, lsu_done_o}, 32'd0);
        checkOutput("post_rst_resp ready", {31'b0, lsu_ready_o}, 32'd1);
        repeat (2) step();

        checkOutput("scoreboard_drained", expQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
